// File: rtl/puf_soc_race_ctrl.sv
// Race sequencer for the ring-oscillator PUF datapath: walks a run of challenges,
// clears/settles/enables the RO counter pair, captures the comparator verdict (or a
// timeout) and hands one response record per challenge to the consumer.
module puf_soc_race_ctrl #(
    parameter int CNT_BIT_SIZE = 32,
    parameter int CHAL_W       = 8,
    parameter int SETTLE_CYC   = 16,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [CHAL_W-1:0]       i_chal_base,
    input  logic [CHAL_W-1:0]       i_chal_num,
    input  logic                    i_comp_valid,
    input  logic                    i_full_0,
    input  logic                    i_full_1,
    input  logic [CNT_BIT_SIZE-1:0] i_loser,
    output logic [CHAL_W-1:0]       o_challenge,
    output logic                    o_cnt_clr,
    output logic                    o_cnt_en,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [CHAL_W-1:0]       o_resp_chal,
    output logic                    o_resp_bit,
    output logic                    o_resp_tie,
    output logic                    o_resp_timeout,
    output logic [CNT_BIT_SIZE-1:0] o_resp_loser,
    output logic                    o_busy,
    output logic                    o_done
);

    typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, RACE, OUT, DONE} state_t;

    localparam logic [31:0]       SETTLE_LAST  = 32'(SETTLE_CYC - 1);
    localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [CHAL_W-1:0] CHAL_ONE     = CHAL_W'(1);

    state_t                  state_q, state_d;
    logic [CHAL_W-1:0]       base_q, base_d;
    logic [CHAL_W-1:0]       num_q, num_d;
    logic [CHAL_W-1:0]       idx_q, idx_d;
    logic [31:0]             timer_q, timer_d;
    logic [CHAL_W-1:0]       chal_q, chal_d;
    logic                    bit_q, bit_d;
    logic                    tie_q, tie_d;
    logic                    tmo_q, tmo_d;
    logic [CNT_BIT_SIZE-1:0] loser_q, loser_d;
    logic                    cnt_clr_q, cnt_en_q, resp_valid_q, busy_q, done_q;

    // Next-state, run bookkeeping and record capture.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        chal_d  = chal_q;
        bit_d   = bit_q;
        tie_d   = tie_q;
        tmo_d   = tmo_q;
        loser_d = loser_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    base_d = i_chal_base;
                    num_d  = i_chal_num;
                    idx_d  = '0;
                    if (i_chal_num == '0) begin
                        state_d = DONE;
                    end else begin
                        chal_d  = i_chal_base;
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                timer_d = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = RACE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            RACE: begin
                // A verdict on the last enabled cycle takes priority over timeout.
                if (i_comp_valid) begin
                    bit_d   = i_full_1 & ~i_full_0;
                    tie_d   = i_full_1 & i_full_0;
                    tmo_d   = 1'b0;
                    loser_d = i_loser;
                    state_d = OUT;
                end else if (timer_q == TIMEOUT_LAST) begin
                    bit_d   = 1'b0;
                    tie_d   = 1'b0;
                    tmo_d   = 1'b1;
                    loser_d = '0;
                    state_d = OUT;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            OUT: begin
                if (i_resp_ready) begin
                    if (idx_q == num_q - CHAL_ONE) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + CHAL_ONE;
                        chal_d  = base_q + idx_q + CHAL_ONE;
                        state_d = CLEAR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; control outputs are registered from the next state
    // so they line up exactly with the state they belong to.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            num_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            chal_q       <= '0;
            bit_q        <= 1'b0;
            tie_q        <= 1'b0;
            tmo_q        <= 1'b0;
            loser_q      <= '0;
            cnt_clr_q    <= 1'b0;
            cnt_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            num_q        <= num_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            chal_q       <= chal_d;
            bit_q        <= bit_d;
            tie_q        <= tie_d;
            tmo_q        <= tmo_d;
            loser_q      <= loser_d;
            cnt_clr_q    <= (state_d == CLEAR);
            cnt_en_q     <= (state_d == RACE);
            resp_valid_q <= (state_d == OUT);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
        end
    end

    assign o_challenge    = chal_q;
    assign o_cnt_clr      = cnt_clr_q;
    assign o_cnt_en       = cnt_en_q;
    assign o_resp_valid   = resp_valid_q;
    assign o_resp_chal    = chal_q;
    assign o_resp_bit     = bit_q;
    assign o_resp_tie     = tie_q;
    assign o_resp_timeout = tmo_q;
    assign o_resp_loser   = loser_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_puf_soc_race_ctrl.sv
// Scoreboard bench for puf_soc_race_ctrl: stimulus pushes hand-computed records,
// a negedge monitor pops and compares them on each response handshake.
module tb_puf_soc_race_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  chal_base;
    logic [7:0]  chal_num;
    logic        comp_valid;
    logic        full_0;
    logic        full_1;
    logic [31:0] loser;
    logic [7:0]  challenge;
    logic        cnt_clr;
    logic        cnt_en;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_chal;
    logic        resp_bit;
    logic        resp_tie;
    logic        resp_timeout;
    logic [31:0] resp_loser;
    logic        busy;
    logic        done;

    puf_soc_race_ctrl #(
        .CNT_BIT_SIZE(32),
        .CHAL_W      (8),
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_chal_base   (chal_base),
        .i_chal_num    (chal_num),
        .i_comp_valid  (comp_valid),
        .i_full_0      (full_0),
        .i_full_1      (full_1),
        .i_loser       (loser),
        .o_challenge   (challenge),
        .o_cnt_clr     (cnt_clr),
        .o_cnt_en      (cnt_en),
        .o_resp_valid  (resp_valid),
        .i_resp_ready  (resp_ready),
        .o_resp_chal   (resp_chal),
        .o_resp_bit    (resp_bit),
        .o_resp_tie    (resp_tie),
        .o_resp_timeout(resp_timeout),
        .o_resp_loser  (resp_loser),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  chal;
        logic        b;
        logic        t;
        logic        to;
        logic [31:0] los;
    } rec_t;

    rec_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    // Comparator model settings for the current run.
    int          rsp_delay = 0;   // enabled cycle carrying the verdict, 0 = never
    logic        rsp_f1 = 1'b0;
    logic        rsp_f0 = 1'b0;
    logic [31:0] rsp_loser = '0;
    int          exp_en = 0;      // expected enabled cycles per race
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Comparator responder: counts enabled cycles, raises verdict on the chosen one.
    initial begin
        int en_c;
        en_c = 0;
        comp_valid = 1'b0;
        full_0 = 1'b0;
        full_1 = 1'b0;
        loser = '0;
        forever begin
            @(negedge clk);
            full_0 = rsp_f0;
            full_1 = rsp_f1;
            loser  = rsp_loser;
            if (cnt_clr) en_c = 0;
            if (cnt_en) begin
                en_c++;
                comp_valid = (rsp_delay != 0) && (en_c == rsp_delay);
            end else begin
                comp_valid = 1'b0;
            end
        end
    end

    // Monitor: phase accounting, stability under backpressure, scoreboard pops.
    initial begin
        int   clr_c, set_c, en_c;
        logic prev_valid;
        rec_t cur, snap, e;
        clr_c = 0; set_c = 0; en_c = 0; prev_valid = 1'b0; snap = '0;
        forever begin
            @(negedge clk);
            cur = {resp_chal, resp_bit, resp_tie, resp_timeout, resp_loser};
            if (!rst_n) begin
                clr_c = 0; set_c = 0; en_c = 0; prev_valid = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (cnt_clr) clr_c++;
                if (cnt_en) en_c++;
                if (busy && !cnt_clr && !cnt_en && !resp_valid && !done) set_c++;
                if (resp_valid && !prev_valid) begin
                    chk("clr_cycles", 64'(clr_c), 64'd1);
                    chk("settle_cycles", 64'(set_c), 64'd4);
                    chk("en_cycles", 64'(en_c), 64'(exp_en));
                    clr_c = 0; set_c = 0; en_c = 0;
                    snap = cur;
                end
                if (resp_valid && !resp_ready) begin
                    chk("bp_stable", 64'(cur), 64'(snap));
                    chk("bp_en_clr", {62'd0, cnt_en, cnt_clr}, 64'd0);
                end
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_record", 64'(cur), 64'd0);
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_record: got 0x%0h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("record", 64'(cur), 64'(e));
                    end
                end
                prev_valid = resp_valid;
            end
        end
    end

    task automatic set_rsp(input int d, input logic f1, input logic f0,
                           input logic [31:0] l, input int en);
        rsp_delay = d; rsp_f1 = f1; rsp_f0 = f0; rsp_loser = l; exp_en = en;
    endtask

    task automatic start_run(input logic [7:0] base, input logic [7:0] num,
                             input logic b, input logic t, input logic to,
                             input logic [31:0] l);
        logic [7:0] c;
        for (int i = 0; i < int'(num); i++) begin
            c = base + 8'(i);
            exp_q.push_back({c, b, t, to, l});
        end
        @(posedge clk); #1;
        chal_base = base; chal_num = num; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; chal_base = 8'hAA; chal_num = 8'h55;
    endtask

    task automatic wait_done(input int d0);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        chk("done_once", 64'(done_cnt), 64'(d0 + 1));
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit got;
        rst_n = 1'b0; start = 1'b0; chal_base = '0; chal_num = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {resp_chal, resp_bit, resp_tie, resp_timeout, resp_loser,
                              challenge, cnt_clr, cnt_en, resp_valid, busy, done}, 64'd0);
        rst_n = 1'b1;

        // Normal run, full_0 wins after 5 enabled cycles; a mid-run start is ignored.
        set_rsp(5, 1'b0, 1'b1, 32'h20, 5);
        d0 = done_cnt;
        start_run(8'h10, 8'd3, 1'b0, 1'b0, 1'b0, 32'h20);
        repeat (3) @(posedge clk);
        #1; chal_base = 8'h80; chal_num = 8'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(d0);

        // full_1 wins.
        set_rsp(3, 1'b1, 1'b0, 32'h7, 3);
        d0 = done_cnt;
        start_run(8'h20, 8'd1, 1'b1, 1'b0, 1'b0, 32'h7);
        wait_done(d0);

        // Tie.
        set_rsp(2, 1'b1, 1'b1, 32'hFFFF_FFFF, 2);
        d0 = done_cnt;
        start_run(8'h21, 8'd1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        wait_done(d0);

        // Timeout: no verdict; loser input nonzero must not leak into the record.
        set_rsp(0, 1'b1, 1'b0, 32'h55, 8);
        d0 = done_cnt;
        start_run(8'h30, 8'd1, 1'b0, 1'b0, 1'b1, 32'h0);
        wait_done(d0);

        // Verdict on the final timeout cycle wins.
        set_rsp(8, 1'b0, 1'b1, 32'h33, 8);
        d0 = done_cnt;
        start_run(8'h31, 8'd1, 1'b0, 1'b0, 1'b0, 32'h33);
        wait_done(d0);

        // Backpressure for 10 cycles on the first record of a two-challenge run.
        set_rsp(4, 1'b1, 1'b0, 32'h44, 4);
        d0 = done_cnt;
        resp_ready = 1'b0;
        start_run(8'h50, 8'd2, 1'b1, 1'b0, 1'b0, 32'h44);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1; break; end
        end
        chk("bp_valid_seen", 64'(got), 64'd1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1; resp_ready = 1'b1;
        wait_done(d0);

        // Empty run: done one cycle after start, no record.
        d0 = done_cnt;
        @(posedge clk); #1; chal_base = 8'h77; chal_num = 8'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("empty_done", {62'd0, done, busy}, 64'd3);
        @(posedge clk); #1;
        chk("empty_idle", {62'd0, done, busy}, 64'd0);
        @(negedge clk);
        chk("empty_done_once", 64'(done_cnt), 64'(d0 + 1));

        // Challenge wrap past all-ones.
        set_rsp(2, 1'b1, 1'b0, 32'h1, 2);
        d0 = done_cnt;
        start_run(8'hFE, 8'd3, 1'b1, 1'b0, 1'b0, 32'h1);
        wait_done(d0);

        // Reset during RACE aborts the run without a record or done.
        set_rsp(0, 1'b0, 1'b1, 32'h9, 3);
        d0 = done_cnt;
        start_run(8'h40, 8'd2, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.delete();
        exp_q.delete();
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cnt_en) begin got = 1; break; end
        end
        chk("abort_race_seen", 64'(got), 64'd1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        chk("abort_outputs", {resp_chal, resp_bit, resp_tie, resp_timeout, resp_loser,
                              challenge, cnt_clr, cnt_en, resp_valid, busy, done}, 64'd0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        chk("abort_idle", {62'd0, busy, resp_valid}, 64'd0);

        // Restart begins again at idx 0.
        set_rsp(3, 1'b0, 1'b1, 32'h9, 3);
        d0 = done_cnt;
        start_run(8'h40, 8'd1, 1'b0, 1'b0, 1'b0, 32'h9);
        wait_done(d0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/puf_soc_race_ctrl.md
Name: puf_soc_race_ctrl

Overview:
- Sequencer for the ring-oscillator race datapath: two RO counters feed the full/count comparator.
- For each challenge in a programmed run it applies the challenge, clears the counters, lets the oscillators settle, enables counting, and waits for the comparator verdict or a timeout.
- It then emits one response record per challenge over a valid/ready handshake.
- Sits between the SoC register interface (start/config) and the counter + comparator pair.

Parameters:
- CNT_BIT_SIZE, 32, width of the RO counters and of the comparator loser count.
- CHAL_W, 8, challenge width; also the width of the run-length field.
- SETTLE_CYC, 16, cycles between challenge change and counter enable (≥1).
- TIMEOUT_CYC, 65535, maximum enabled cycles per race before declaring timeout (≥1).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  one-cycle start pulse; honoured only in IDLE.
- i_chal_base  in  CHAL_W  first challenge of the run; sampled on accepted start.
- i_chal_num  in  CHAL_W  number of challenges in the run; sampled on accepted start; 0 = empty run.
- i_comp_valid  in  1  comparator verdict valid.
- i_full_0  in  1  counter 0 reached full.
- i_full_1  in  1  counter 1 reached full.
- i_loser  in  CNT_BIT_SIZE  comparator loser count.
- o_challenge  out  CHAL_W  challenge driven to the RO mux.
- o_cnt_clr  out  1  counter synchronous clear.
- o_cnt_en  out  1  counter enable.
- o_resp_valid  out  1  response record valid.
- i_resp_ready  in  1  consumer ready.
- o_resp_chal  out  CHAL_W  challenge this record belongs to.
- o_resp_bit  out  1  response bit.
- o_resp_tie  out  1  both counters full in the same cycle.
- o_resp_timeout  out  1  race timed out.
- o_resp_loser  out  CNT_BIT_SIZE  captured loser count.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse at end of run.

Behaviour:
- All outputs are registered. During reset (i_rst_n=0 at an edge), every output is 0 and the FSM is in IDLE; the index and timers are cleared.
- Reset asserted mid-run aborts the run immediately. No record or o_done is produced for the aborted run.
- States: IDLE, CLEAR, SETTLE, RACE, OUT, DONE.
- IDLE:
  - On i_start, latch base and num, set idx=0, o_busy=1.
  - If num==0, go to DONE; else go to CLEAR.
  - i_start in any other state is ignored.
- CLEAR:
  - Exactly 1 cycle.
  - o_challenge = base+idx, modulo 2^CHAL_W (wraps).
  - o_cnt_clr=1, o_cnt_en=0.
  - Next state: SETTLE.
- SETTLE:
  - Exactly SETTLE_CYC cycles with o_cnt_clr=0 and o_cnt_en=0.
  - Next state: RACE.
- RACE:
  - o_cnt_en=1; a timer counts enabled cycles.
  - Verdict: on the first cycle i_comp_valid=1, capture the record and go to OUT.
    - {full_1,full_0}=01: bit=0, tie=0.
    - {full_1,full_0}=10: bit=1, tie=0.
    - {full_1,full_0}=11: bit=0, tie=1.
    - In all three cases loser=i_loser and timeout=0.
  - Timeout: if the timer reaches TIMEOUT_CYC with no verdict, go to OUT with timeout=1, bit=0, tie=0, loser=0.
  - A verdict arriving on the final timeout cycle wins over timeout.
  - o_cnt_en drops on the cycle OUT is entered, so the counters freeze.
  - i_comp_valid outside RACE is ignored.
- OUT:
  - o_resp_valid=1. All o_resp_* fields are stable until the handshake (valid & ready at a clock edge).
  - o_cnt_en=0.
  - On handshake:
    - If idx==num-1, go to DONE.
    - Else idx++ and go to CLEAR.
  - o_resp_valid deasserts the cycle after the handshake.
  - Backpressure of any length is legal.
- DONE:
  - 1 cycle; o_done=1.
  - Next state: IDLE, where o_busy=0.
- The index counter is CHAL_W bits. A run of up to 2^CHAL_W−1 challenges is supported, and the challenge sequence wraps past all-ones back to 0.
- Minimum time per challenge: 1 (CLEAR) + SETTLE_CYC + race cycles + 1 (OUT with ready high).

Test Plan:
- Normal run: SETTLE_CYC=4, base=0x10, num=3; full_0 wins each race after 5 enabled cycles with loser=0x20, ready held high.
  - Expect 3 records, chal 0x10/0x11/0x12, bit=0, loser=0x20.
  - Each record preceded by exactly 1 cnt_clr cycle and 4 settle cycles.
  - o_done pulses once, then o_busy=0.
- Full_1 win and tie:
  - {full_1,full_0}=10 with loser=0x7 → bit=1, tie=0, loser=0x7.
  - 11 with loser=0xFFFFFFFF → bit=0, tie=1, loser=0xFFFFFFFF.
- Timeout: TIMEOUT_CYC=8, i_comp_valid never asserted.
  - Expect o_cnt_en high exactly 8 cycles, then a record with timeout=1, loser=0.
  - Repeat with a verdict on enabled cycle 8 → timeout=0.
- Backpressure: i_resp_ready low for 10 cycles while valid.
  - Expect fields stable and o_cnt_en=0 throughout.
  - Expect the next CLEAR only after the handshake.
- Boundaries:
  - num=0 → o_done one cycle after start, no record.
  - base=0xFE, num=3 → chal 0xFE, 0xFF, 0x00.
  - i_start pulsed mid-run → ignored.
- Reset mid-RACE (i_rst_n=0 one edge):
  - Expect all outputs 0 and IDLE next cycle, with no o_done.
  - A new start then begins again at idx=0.
